mmio_uart_tx: RTL and testbench
===============================

# mmio_uart_tx

Memory-mapped UART transmitter on the `scm_mcu` data-memory port. It decodes the core's data-side write bus (`A_dm`, `write_data_dm`, `we_dm`) for its own address window and queues written bytes in a small FIFO. It serialises those bytes as 8N1 frames on `tx`. It also returns a status word that the core's load mux selects when `hit` is high. This gives firmware and benches a real output channel instead of a magic store address.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0400: base of the 16-byte register window. Must be 16-byte aligned.
- `CLK_DIV`, 868: clock cycles per bit. Legal range is 2..65535.
- `FIFO_DEPTH`, 8: TX FIFO entries. Must be a power of two, at least 2.

Ports:
- `clk`, input, 1: rising-edge clock, shared with `scm_mcu`.
- `rst`, input, 1: reset. Asynchronous and active-low: 0 resets, 1 runs.
- `A_dm`, input, 32: data address from the core.
- `write_data_dm`, input, 32: store data from the core.
- `we_dm`, input, 1: store strobe from the core.
- `hit`, output, 1: combinational. High when `A_dm` lies in the window.
- `rd_data`, output, 32: combinational read data for the decoded register. Zero when `hit` is low.
- `tx`, output, 1: serial line. Idles high.
- `irq_empty`, output, 1: registered. High while the FIFO is empty and the shifter is idle.

## Operation
- Address decode: `hit = (A_dm[31:4] == BASE_ADDR[31:4])`. The register is selected by offset `A_dm[3:2]`.
- Offset 0, TXDATA:
  - A write with `hit & we_dm` pushes `write_data_dm[7:0]`.
  - A read returns 0.
- Offset 1, STATUS:
  - Read layout: bit0 full, bit1 empty, bit2 busy (shifter not IDLE), bit3 overflow (sticky). Bits[7+W:8] hold the FIFO count, where W = log2(FIFO_DEPTH)+1. All other bits read 0.
  - A write with bit3=1 clears overflow. All other bits are ignored.
- Offsets 2 and 3: reads return 0 and writes are ignored.
- Push while full: the byte is dropped and overflow is set. Fullness is evaluated before any pop in the same cycle, so a simultaneous pop does not rescue the write.
- Shifter FSM states are IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. When the FIFO is non-empty, pop the head byte into an 8-bit shift register and go to START.
  - START: `tx`=0 for CLK_DIV cycles, then go to DATA with bit index 0.
  - DATA: `tx` = shift[0] for CLK_DIV cycles, then shift right. Repeat for 8 bits (LSB first), then go to STOP.
  - STOP: `tx`=1 for CLK_DIV cycles. At the end, if the FIFO is non-empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter:
  - Width is $clog2(CLK_DIV).
  - It is reloaded to 0 on every state or bit change.
  - A bit ends when the count reaches CLK_DIV-1.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full and empty are derived from a separate count register (0..FIFO_DEPTH).
- Reset, including mid-frame:
  - Outputs and state: `tx`=1, FSM=IDLE, FIFO emptied (count 0, pointers 0), overflow=0, `irq_empty`=1, baud counter 0.
  - The partial frame is abandoned and is not resumed.

## Timing
- A push is registered on the rising edge E where `hit & we_dm & A_dm[3:2]==0`. STATUS count reflects it after E.
- From IDLE with an empty FIFO, the pop happens at E+1 and `tx` falls at E+1.
- One frame is exactly 10×CLK_DIV cycles. Back-to-back frames are contiguous.
- `hit` and `rd_data` are combinational from `A_dm` and the current state, with zero latency. This is required for single-cycle loads.
- `irq_empty` is updated on the same edge that the FSM enters IDLE with the FIFO empty. It falls on the edge that accepts a push.
- The overflow set (edge E) and a clear write cannot occur in the same cycle, because there is only one store per cycle.

## Structure
- Put the following in shared package `mcu_pkg`:
  - Register offsets: `UART_TXDATA_OFS`=2'd0, `UART_STATUS_OFS`=2'd1.
  - STATUS bit indices.
  - The FSM state encoding: IDLE=0, START=1, DATA=2, STOP=3.
- Sub-module `sync_fifo`, parameterised width and depth, with push, pop, full, empty and count. It is reusable for a future RX block.
- The top level holds the decode, the STATUS mux, the overflow flag, the baud counter and the FSM.

## Test plan
All scenarios use CLK_DIV=4 and FIFO_DEPTH=4.
- Reset: hold `rst`=0 for 3 cycles, then release → `tx`=1, STATUS reads 32'h0000_0002, `irq_empty`=1. Asserting `rst`=0 mid-frame forces `tx`=1 immediately and STATUS back to 32'h2.
- Single byte: store 32'h0000_0055 to BASE+0 → `tx` falls one cycle after the store edge. The line then carries 0,1,0,1,0,1,0,1,0,1, each bit for 4 cycles (40 cycles total). `irq_empty` returns to 1.
- Back-to-back: store 8'hA5 then 8'h3C on consecutive cycles → two frames totalling 80 cycles with no high gap between the stop bit and the second start bit. The FIFO count reads 1 during the first frame.
- Overflow: store 6 bytes in 6 cycles starting from idle → 5 bytes are accepted (one is popped at once, leaving 4 queued) and the 6th is dropped. STATUS bit3=1. After writing 32'h8 to BASE+4, bit3=0.
- Decode: store to BASE+16 and to BASE+8 → no push, `hit`=0 for BASE+16, and `rd_data`=0 for both.
- Read-back: read BASE+4 while busy with 2 queued → `rd_data`=32'h0000_0204.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared definitions for scm_mcu peripherals: UART register map, STATUS layout
// and the transmit shifter state encoding.
package mcu_pkg;

  localparam logic [1:0] UART_TXDATA_OFS = 2'd0;
  localparam logic [1:0] UART_STATUS_OFS = 2'd1;

  localparam int UART_ST_FULL      = 0;
  localparam int UART_ST_EMPTY     = 1;
  localparam int UART_ST_BUSY      = 2;
  localparam int UART_ST_OVF       = 3;
  localparam int UART_ST_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    UART_IDLE  = 2'd0,
    UART_START = 2'd1,
    UART_DATA  = 2'd2,
    UART_STOP  = 2'd3
  } uart_state_e;

  // Count is passed zero-extended; bits above the real count width stay zero.
  function automatic logic [31:0] uart_status_word(input logic        full,
                                                   input logic        empty,
                                                   input logic        busy,
                                                   input logic        ovf,
                                                   input logic [15:0] count);
    logic [31:0] word;
    word                              = '0;
    word[UART_ST_FULL]                = full;
    word[UART_ST_EMPTY]               = empty;
    word[UART_ST_BUSY]                = busy;
    word[UART_ST_OVF]                 = ovf;
    word[UART_ST_COUNT_LSB +: 16]     = count;
    return word;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter; full/empty come from
// the counter so pointers may wrap freely. Shared by the UART TX and future RX.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // Fullness is judged on the registered count, so a same-cycle pop never
  // makes room for a push into a full FIFO.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter on the scm_mcu data port: window decode,
// STATUS read mux, sticky overflow, baud counter and the frame shifter.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for CLK_DIV cycles
//   DATA  | 8 data bits, LSB first
//   STOP  | stop bit (high); pops the next byte straight into START
module mmio_uart_tx
  import mcu_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0400,
  parameter int unsigned CLK_DIV    = 868,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A_dm,
  input  logic [31:0] write_data_dm,
  input  logic        we_dm,
  output logic        hit,
  output logic [31:0] rd_data,
  output logic        tx,
  output logic        irq_empty
);

  localparam int unsigned CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);

  logic [1:0]      ofs;
  logic            wr_txdata, wr_status;
  logic            fifo_full, fifo_empty, fifo_pop;
  logic [7:0]      fifo_rdata;
  logic [CNTW-1:0] fifo_count;
  logic            push_ok;
  logic            bit_end;
  logic            overflow_q, overflow_d;
  logic [31:0]     status_word;
  logic            unused_bits;

  uart_state_e     state_q;
  logic [CW-1:0]   baud_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            irq_empty_q;

  assign unused_bits = ^{A_dm[1:0], write_data_dm[31:8]};

  assign hit       = (A_dm[31:4] == BASE_ADDR[31:4]);
  assign ofs       = A_dm[3:2];
  assign wr_txdata = hit & we_dm & (ofs == UART_TXDATA_OFS);
  assign wr_status = hit & we_dm & (ofs == UART_STATUS_OFS);
  assign push_ok   = wr_txdata & ~fifo_full;
  assign bit_end   = (baud_q == BAUD_LAST);

  // The shifter takes a byte whenever it is free to start a frame: from IDLE
  // at once, or at the end of a stop bit so frames run back to back.
  assign fifo_pop = ~fifo_empty &
                    ((state_q == UART_IDLE) || ((state_q == UART_STOP) && bit_end));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (wr_txdata),
    .pop_i   (fifo_pop),
    .wdata_i (write_data_dm[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    overflow_d = overflow_q;
    if (wr_txdata && fifo_full)                         overflow_d = 1'b1;
    else if (wr_status && write_data_dm[UART_ST_OVF])   overflow_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) overflow_q <= 1'b0;
    else      overflow_q <= overflow_d;
  end

  always_comb begin
    status_word = uart_status_word(fifo_full, fifo_empty, (state_q != UART_IDLE),
                                   overflow_q, 16'(fifo_count));
    rd_data = '0;
    if (hit && (ofs == UART_STATUS_OFS)) rd_data = status_word;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= UART_IDLE;
      baud_q      <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      tx_q        <= 1'b1;
      irq_empty_q <= 1'b1;
    end else begin
      // An accepted push outranks entering IDLE in the same cycle.
      if (push_ok)
        irq_empty_q <= 1'b0;
      else if ((state_q == UART_STOP) && bit_end && fifo_empty)
        irq_empty_q <= 1'b1;

      case (state_q)
        UART_IDLE: begin
          baud_q <= '0;
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
            state_q <= UART_START;
            tx_q    <= 1'b0;
          end
        end
        UART_START: begin
          if (bit_end) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= UART_DATA;
            tx_q      <= shift_q[0];
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        UART_DATA: begin
          if (bit_end) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              state_q <= UART_STOP;
              tx_q    <= 1'b1;
            end else begin
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        UART_STOP: begin
          if (bit_end) begin
            baud_q <= '0;
            if (!fifo_empty) begin
              shift_q <= fifo_rdata;
              state_q <= UART_START;
              tx_q    <= 1'b0;
            end else begin
              state_q <= UART_IDLE;
              tx_q    <= 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          state_q <= UART_IDLE;
          baud_q  <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx        = tx_q;
  assign irq_empty = irq_empty_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed + randomized bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=4) with a
// line decoder and an occupancy model derived from the frame/queue rules.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam int          DIV  = 4;
  localparam int          DEP  = 4;

  logic        clk;
  logic        rst;
  logic [31:0] A_dm;
  logic [31:0] write_data_dm;
  logic        we_dm;
  logic        hit;
  logic [31:0] rd_data;
  logic        tx;
  logic        irq_empty;

  int          checks = 0;
  int          errors = 0;

  logic [8:0]  rxq[$];
  logic [7:0]  mon_b;
  logic        mon_stop;

  logic [31:0] rdv;
  logic [7:0]  bur[6];
  logic [7:0]  b2[2];
  int          k_burst;
  int          n_exp;
  int          queued;
  int          lows;

  mmio_uart_tx #(
    .BASE_ADDR  (BASE),
    .CLK_DIV    (DIV),
    .FIFO_DEPTH (DEP)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .A_dm          (A_dm),
    .write_data_dm (write_data_dm),
    .we_dm         (we_dm),
    .hit           (hit),
    .rd_data       (rd_data),
    .tx            (tx),
    .irq_empty     (irq_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Independent 8N1 receiver: finds the first low sample, then samples mid-bit.
  always begin : rx_mon
    @(negedge clk);
    if (rst === 1'b1 && tx === 1'b0) begin
      repeat (5) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        mon_b[i] = tx;
        if (i < 7) repeat (DIV) @(negedge clk);
      end
      repeat (DIV) @(negedge clk);
      mon_stop = tx;
      rxq.push_back({mon_stop, mon_b});
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Line level of frame bit slot idx (0 start, 1..8 data LSB first, 9 stop).
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  function automatic logic [31:0] st_exp(input int q, input logic busy, input logic ovf);
    logic [31:0] w;
    w = 32'(q) << 8;
    w[0] = (q == DEP);
    w[1] = (q == 0);
    w[2] = busy;
    w[3] = ovf;
    return w;
  endfunction

  // Called at posedge+1; leaves the bench at the next posedge+1.
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    A_dm = a; write_data_dm = d; we_dm = 1'b1;
    @(posedge clk); #1;
    we_dm = 1'b0;
  endtask

  task automatic read_reg(input logic [31:0] a, output logic [31:0] d);
    A_dm = a; we_dm = 1'b0;
    #1;
    d = rd_data;
  endtask

  task automatic wait_idle(input int bound, input string tag);
    int n;
    n = 0;
    while (irq_empty !== 1'b1 && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, irq_empty, 1'b1);
  endtask

  initial begin
    rst = 1'b0; A_dm = '0; write_data_dm = '0; we_dm = 1'b0;

    // Reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_tx", tx, 1'b1);
    check("rst_hold_irq", irq_empty, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_tx", tx, 1'b1);
    check("rst_irq", irq_empty, 1'b1);
    read_reg(BASE + 4, rdv);
    check("rst_hit", hit, 1'b1);
    check("rst_status", rdv, 32'h0000_0002);

    // Single byte, cycle-exact line check
    rxq.delete();
    store(BASE, 32'h0000_0055);
    check("single_tx_pre", tx, 1'b1);
    check("single_irq_fall", irq_empty, 1'b0);
    read_reg(BASE + 4, rdv);
    check("single_status_queued", rdv, st_exp(1, 1'b0, 1'b0));
    @(posedge clk); #1;
    for (int i = 0; i < 10 * DIV; i++) begin
      check($sformatf("single_line_c%0d", i), tx, frame_bit(8'h55, i / DIV));
      @(posedge clk); #1;
    end
    check("single_irq_rise", irq_empty, 1'b1);
    check("single_rx_count", rxq.size(), 1);
    if (rxq.size() > 0) check("single_rx_byte", rxq[0], {1'b1, 8'h55});

    // Back-to-back frames with no gap
    rxq.delete();
    b2[0] = 8'hA5; b2[1] = 8'h3C;
    store(BASE, {24'h00_0000, b2[0]});
    store(BASE, {$urandom_range(0, 32'hFF_FFFF), b2[1]});
    read_reg(BASE + 4, rdv);
    check("b2b_status_count1", rdv, st_exp(1, 1'b1, 1'b0));
    for (int i = 0; i < 20 * DIV; i++) begin
      check($sformatf("b2b_line_c%0d", i), tx, frame_bit(b2[i / (10 * DIV)], (i % (10 * DIV)) / DIV));
      @(posedge clk); #1;
    end
    check("b2b_irq_rise", irq_empty, 1'b1);
    check("b2b_rx_count", rxq.size(), 2);
    for (int j = 0; j < 2 && j < rxq.size(); j++)
      check($sformatf("b2b_rx_byte%0d", j), rxq[j], {1'b1, b2[j]});

    // Address decode
    read_reg(BASE + 16, rdv);
    check("dec_hit_out", hit, 1'b0);
    check("dec_rd_out", rdv, 32'h0);
    store(BASE + 16, 32'h0000_0077);
    read_reg(BASE + 8, rdv);
    check("dec_hit_ofs2", hit, 1'b1);
    check("dec_rd_ofs2", rdv, 32'h0);
    store(BASE + 8, 32'h0000_0077);
    read_reg(BASE + 12, rdv);
    check("dec_rd_ofs3", rdv, 32'h0);
    read_reg(BASE, rdv);
    check("dec_rd_txdata", rdv, 32'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("dec_tx_idle", tx, 1'b1);
    check("dec_irq", irq_empty, 1'b1);
    read_reg(BASE + 4, rdv);
    check("dec_status", rdv, 32'h0000_0002);

    // Randomized bursts from idle: the first byte leaves for the shifter on the
    // next cycle, so the FIFO can hold DEP more; anything beyond is dropped.
    for (int it = 0; it < 8; it++) begin
      k_burst = (it == 0) ? 6 : (it == 1) ? 3 : $urandom_range(1, 6);
      rxq.delete();
      for (int j = 0; j < k_burst; j++) begin
        bur[j] = 8'($urandom);
        store(BASE, {$urandom_range(0, 32'hFF_FFFF), bur[j]});
      end
      check($sformatf("burst%0d_irq_low", it), irq_empty, 1'b0);
      n_exp = (k_burst < DEP + 1) ? k_burst : DEP + 1;
      if (k_burst >= 2) begin
        queued = n_exp - 1;
        read_reg(BASE + 4, rdv);
        check($sformatf("burst%0d_status", it), rdv, st_exp(queued, 1'b1, k_burst > DEP + 1));
      end
      if (k_burst == 6) begin
        store(BASE + 4, 32'hFFFF_FFF7);
        read_reg(BASE + 4, rdv);
        check($sformatf("burst%0d_ovf_kept", it), rdv[3], 1'b1);
        store(BASE + 4, 32'h0000_0008);
        read_reg(BASE + 4, rdv);
        check($sformatf("burst%0d_ovf_clr", it), rdv, st_exp(DEP, 1'b1, 1'b0));
      end
      wait_idle(10 * DIV * 7, $sformatf("burst%0d_drain", it));
      check($sformatf("burst%0d_rx_count", it), rxq.size(), n_exp);
      for (int j = 0; j < n_exp && j < rxq.size(); j++)
        check($sformatf("burst%0d_rx%0d", it, j), rxq[j], {1'b1, bur[j]});
      read_reg(BASE + 4, rdv);
      check($sformatf("burst%0d_status_idle", it), rdv, 32'h0000_0002);
    end

    // Reset mid-frame abandons the frame and the queue
    store(BASE, 32'h0000_00F0);
    store(BASE, 32'h0000_000F);
    repeat (15) begin @(posedge clk); #1; end
    A_dm = BASE + 4;
    rst = 1'b0;
    #1;
    check("midrst_tx", tx, 1'b1);
    check("midrst_irq", irq_empty, 1'b1);
    check("midrst_status", rd_data, 32'h0000_0002);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    lows = 0;
    for (int i = 0; i < 12 * DIV; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    check("midrst_no_resume", lows, 0);
    read_reg(BASE + 4, rdv);
    check("midrst_status_after", rdv, 32'h0000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
